am_envelope_demod: RTL and testbench

Iterative-CORDIC AM envelope detector downstream of the I and Q `cic` decimators. It takes one decimated I/Q sample pair per `in_tick` and computes the magnitude sqrt(I²+Q²). It optionally removes the carrier DC level and emits one signed audio sample with a one-cycle `out_tick`, which feeds the audio output stage.

---
 rtl/am_envelope_demod.sv | 149 ++++++++++++++
 tb/tb_am_envelope_demod.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/am_envelope_demod.sv
// am_envelope_demod
//   Iterative-CORDIC AM envelope detector. Accepts one decimated I/Q pair per
//   in_tick, computes sqrt(I^2+Q^2) by CORDIC vectoring, removes the CORDIC
//   gain with a shift-add constant and emits one signed audio sample per
//   input with a single-cycle out_tick.
//
//   Optional build macro AM_DEMOD_DC_BLOCK_EN: when defined, a first-order
//   DC blocker (pole 1 - 2^-DC_SHIFT) follows the magnitude and the output
//   is saturated to BITS. When undefined, x_out is the halved magnitude.
//
// Ports
//   CLK       clock
//   RSTb      synchronous active-low reset
//   i_in      signed in-phase sample, valid with in_tick
//   q_in      signed quadrature sample, valid with in_tick
//   in_tick   one-cycle input strobe
//   x_out     signed audio sample, held between out_tick pulses
//   out_tick  one-cycle pulse when x_out updates
//   busy      high while a sample is in flight
//   overrun   sticky flag, set by in_tick while busy; cleared only by reset
module am_envelope_demod #(
  parameter int BITS     = 16,
  parameter int ITER     = 12,
  parameter int DC_SHIFT = 8
) (
  input  logic                   CLK,
  input  logic                   RSTb,
  input  logic signed [BITS-1:0] i_in,
  input  logic signed [BITS-1:0] q_in,
  input  logic                   in_tick,
  output logic signed [BITS-1:0] x_out,
  output logic                   out_tick,
  output logic                   busy,
  output logic                   overrun
);

  localparam int W  = BITS + 2;
  localparam int IW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, ROT, SCALE, POST} state_t;

  state_t              state, state_nx;
  logic signed [W-1:0] x, y, mag;
  logic [IW-1:0]       iter;

  logic signed [W-1:0] i_ext, q_ext, i_abs, q_abs;
  logic signed [W-1:0] x_sh, y_sh;

  // Two guard bits make |-2^(BITS-1)| representable and cover CORDIC growth.
  assign i_ext = {{2{i_in[BITS-1]}}, i_in};
  assign q_ext = {{2{q_in[BITS-1]}}, q_in};
  assign i_abs = i_ext[W-1] ? -i_ext : i_ext;
  assign q_abs = q_ext[W-1] ? -q_ext : q_ext;
  assign x_sh  = x >>> iter;
  assign y_sh  = y >>> iter;

`ifdef AM_DEMOD_DC_BLOCK_EN
  localparam int DW = BITS + 4;
  localparam logic signed [DW-1:0] SAT_HI = DW'((64'sd1 <<< (BITS - 1)) - 64'sd1);
  localparam logic signed [DW-1:0] SAT_LO = -SAT_HI - DW'(1);

  logic signed [DW-1:0] dc_d_prev, dc_y_prev, d_ext, y_n;
  logic signed [BITS-1:0] y_sat;

  assign d_ext = {5'b0, (BITS-1)'(mag >>> 1)};
  assign y_n   = d_ext - dc_d_prev + dc_y_prev - (dc_y_prev >>> DC_SHIFT);

  always_comb begin
    y_sat = y_n[BITS-1:0];
    if (y_n > SAT_HI)      y_sat = SAT_HI[BITS-1:0];
    else if (y_n < SAT_LO) y_sat = SAT_LO[BITS-1:0];
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RSTb) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    unique case (state)
      IDLE:  if (in_tick) state_nx = ROT;
      ROT:   if (iter == IW'(ITER - 1)) state_nx = SCALE;
      SCALE: state_nx = POST;
      POST:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      x        <= '0;
      y        <= '0;
      mag      <= '0;
      iter     <= '0;
      x_out    <= '0;
      out_tick <= 1'b0;
`ifdef AM_DEMOD_DC_BLOCK_EN
      dc_d_prev <= '0;
      dc_y_prev <= '0;
`endif
    end else begin
      out_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_tick) begin
            x    <= i_abs;
            y    <= q_abs;
            iter <= '0;
          end
        end
        ROT: begin
          // Vectoring step: drive y toward zero; both updates use old x, y.
          if (!y[W-1]) begin
            x <= x + y_sh;
            y <= y - x_sh;
          end else begin
            x <= x - y_sh;
            y <= y + x_sh;
          end
          iter <= iter + IW'(1);
        end
        SCALE: begin
          // ~0.6074 * x, inverse of the CORDIC gain.
          mag <= (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
        end
        POST: begin
`ifdef AM_DEMOD_DC_BLOCK_EN
          x_out     <= y_sat;
          dc_d_prev <= d_ext;
          dc_y_prev <= y_n;
`else
          x_out     <= {1'b0, (BITS-1)'(mag >>> 1)};
`endif
          out_tick  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTb)              overrun <= 1'b0;
    else if (in_tick && busy) overrun <= 1'b1;
  end

endmodule

// File: tb/tb_am_envelope_demod.sv
// Self-checking bench for am_envelope_demod: directed corners plus a random
// sweep against a real-valued magnitude model sqrt(I^2+Q^2)/2.
module tb_am_envelope_demod;

  localparam int BITS = 16;
  localparam int ITER = 12;
  localparam int LAT  = ITER + 3;

  logic                   CLK = 1'b0;
  logic                   RSTb = 1'b0;
  logic signed [BITS-1:0] i_in = '0;
  logic signed [BITS-1:0] q_in = '0;
  logic                   in_tick = 1'b0;
  logic signed [BITS-1:0] x_out;
  logic                   out_tick;
  logic                   busy;
  logic                   overrun;

  int n_checks = 0;
  int n_errors = 0;

  am_envelope_demod #(.BITS(BITS), .ITER(ITER), .DC_SHIFT(8)) dut (
    .CLK(CLK), .RSTb(RSTb), .i_in(i_in), .q_in(q_in), .in_tick(in_tick),
    .x_out(x_out), .out_tick(out_tick), .busy(busy), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp, input int tol);
    int diff;
    n_checks++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int model_mag(input int i, input int q);
    real m;
    m = $sqrt(real'(i) * real'(i) + real'(q) * real'(q)) / 2.0;
    return int'(m);
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RSTb = 1'b0;
    in_tick = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RSTb = 1'b1;
  endtask

  // One tick, then wait (bounded) for out_tick; reports latency and busy cycles.
  task automatic run_pair(input int i, input int q, output int res,
                          output int lat, output int busy_n);
    @(negedge CLK);
    i_in = BITS'(i);
    q_in = BITS'(q);
    in_tick = 1'b1;
    @(negedge CLK);
    in_tick = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!out_tick && lat < 100) begin
      if (busy) busy_n++;
      @(negedge CLK);
      lat++;
    end
    res = int'(x_out);
  endtask

  initial begin
    int res, lat, bn, cnt, first, prev;
    logic [BITS-1:0] r1, r2;
    int ri, rq;

    do_reset();
    @(negedge CLK);
    check("rst_x_out", int'(x_out), 0, 0);
    check("rst_out_tick", int'(out_tick), 0, 0);
    check("rst_busy", int'(busy), 0, 0);
    check("rst_overrun", int'(overrun), 0, 0);

    // Overrun: second tick 5 cycles after the first is dropped.
    do_reset();
    @(negedge CLK);
    i_in = 16'sd16384; q_in = '0; in_tick = 1'b1;
    @(negedge CLK);
    in_tick = 1'b0;
    cnt = 0; first = 0;
    for (int k = 1; k < 40; k++) begin
      if (k == 5) begin i_in = 16'sd1000; q_in = 16'sd1000; in_tick = 1'b1; end
      if (k == 6) in_tick = 1'b0;
      if (out_tick) begin cnt++; first = int'(x_out); end
      @(negedge CLK);
    end
    check("ovr_ticks", cnt, 1, 0);
    check("ovr_value", first, model_mag(16384, 0), 4);
    check("ovr_flag", int'(overrun), 1, 0);
    run_pair(0, 0, res, lat, bn);
    check("ovr_sticky", int'(overrun), 1, 0);

    // Reset one cycle, 6 cycles into a computation.
    @(negedge CLK);
    i_in = 16'sd20000; q_in = 16'sd5000; in_tick = 1'b1;
    @(negedge CLK);
    in_tick = 1'b0;
    repeat (5) @(negedge CLK);
    RSTb = 1'b0;
    @(negedge CLK);
    RSTb = 1'b1;
    cnt = 0;
    repeat (40) begin
      if (out_tick) cnt++;
      @(negedge CLK);
    end
    check("rmid_ticks", cnt, 0, 0);
    check("rmid_x_out", int'(x_out), 0, 0);
    check("rmid_busy", int'(busy), 0, 0);
    check("rmid_overrun", int'(overrun), 0, 0);

`ifdef AM_DEMOD_DC_BLOCK_EN
    do_reset();
    prev = 0;
    for (int k = 0; k < 2000; k++) begin
      run_pair(16384, 0, res, lat, bn);
      if (k == 0) begin
        check("dc_first", res, 8192, 4);
        check("dc_latency", lat, LAT, 0);
      end else begin
        check("dc_monotonic", int'(res <= prev), 1, 0);
      end
      prev = res;
    end
    // Truncating arithmetic shift stalls the decay once below 2^DC_SHIFT.
    check("dc_final_small", int'(prev >= 0 && prev < 256), 1, 0);
`else
    do_reset();
    run_pair(16384, 0, res, lat, bn);
    check("tone_latency", lat, LAT, 0);
    check("tone_value", res, 8192, 4);
    check("tone_busy_cycles", bn, ITER + 2, 0);
    check("tone_overrun", int'(overrun), 0, 0);

    run_pair(-32768, -32768, res, lat, bn);
    check("fs_value", res, 23170, 8);
    run_pair(0, 0, res, lat, bn);
    check("zero_value", res, 0, 0);
    run_pair(-32768, 0, res, lat, bn);
    check("negfs_i_value", res, model_mag(-32768, 0), 8);
    run_pair(0, 32767, res, lat, bn);
    check("posfs_q_value", res, model_mag(0, 32767), 8);

    for (int k = 0; k < 2000; k++) begin
      r1 = BITS'($urandom);
      r2 = BITS'($urandom);
      ri = int'($signed(r1));
      rq = int'($signed(r2));
      run_pair(ri, rq, res, lat, bn);
      check("rand_value", res, model_mag(ri, rq), 8);
      if (k % 100 == 0) check("rand_latency", lat, LAT, 0);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    check("rand_no_overrun", int'(overrun), 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
